// File: rtl/fetch_queue.sv
// First-word-fall-through fetch queue between instruction fetch and decode.
// Handshake flags come from registered occupancy only; mispredict empties the queue in one cycle.
module fetch_queue #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mispredict,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  T                           data_in,
  output logic                       valid_out,
  input  logic                       ready_out,
  output T                           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flush, push, pop;

  // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign ready_in  = (count_q != CNT_FULL);
  assign valid_out = (count_q != '0);
  assign count     = count_q;
  assign flush     = reset || mispredict;
  assign push      = valid_in && ready_in && !flush;
  assign pop       = valid_out && ready_out && !flush;

  always_comb begin
    data_out = '0;
    if (valid_out) data_out = mem_q[rd_ptr_q];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = data_in;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; the empty-state zeroing of data_out hides stale entries.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a DEPTH=4 instance for the main scenarios
// and a DEPTH=3 instance for non-power-of-two pointer wrap.
module tb_fetch_queue;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, mp_a, vi_a, ri_a, vo_a, ro_a;
  logic [7:0] di_a, do_a;
  logic [2:0] cnt_a;
  logic       rst_b, mp_b, vi_b, ri_b, vo_b, ro_b;
  logic [7:0] di_b, do_b;
  logic [1:0] cnt_b;

  fetch_queue #(.T(logic [7:0]), .DEPTH(4)) u_a (
    .clk(clk), .reset(rst_a), .mispredict(mp_a), .valid_in(vi_a), .ready_in(ri_a),
    .data_in(di_a), .valid_out(vo_a), .ready_out(ro_a), .data_out(do_a), .count(cnt_a)
  );

  fetch_queue #(.T(logic [7:0]), .DEPTH(3)) u_b (
    .clk(clk), .reset(rst_b), .mispredict(mp_b), .valid_in(vi_b), .ready_in(ri_b),
    .data_in(di_b), .valid_out(vo_b), .ready_out(ro_b), .data_out(do_b), .count(cnt_b)
  );

  logic [7:0] sba[$];
  logic [7:0] sbb[$];
  int checks = 0;
  int passed = 0;

  task automatic step_a(input logic vi, input logic [7:0] d, input logic ro,
                        input logic mp, input logic rs);
    logic do_push, do_pop;
    vi_a = vi; di_a = d; ro_a = ro; mp_a = mp; rst_a = rs;
    do_push = vi && (sba.size() != 4) && !(rs || mp);
    do_pop  = ro && (sba.size() != 0) && !(rs || mp);
    if (rs || mp) sba.delete();
    else begin
      if (do_pop) void'(sba.pop_front());
      if (do_push) sba.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic vi, input logic [7:0] d, input logic ro,
                        input logic mp, input logic rs);
    logic do_push, do_pop;
    vi_b = vi; di_b = d; ro_b = ro; mp_b = mp; rst_b = rs;
    do_push = vi && (sbb.size() != 3) && !(rs || mp);
    do_pop  = ro && (sbb.size() != 0) && !(rs || mp);
    if (rs || mp) sbb.delete();
    else begin
      if (do_pop) void'(sbb.pop_front());
      if (do_push) sbb.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    step_a(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
    step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (ri_a !== 1'b1) $display("FAIL reset_ready_in: got %b want 1", ri_a); else passed++;
    checks++; if (vo_a !== 1'b0) $display("FAIL reset_valid_out: got %b want 0", vo_a); else passed++;
    checks++; if (do_a !== 8'h00) $display("FAIL reset_data_out: got %h want 00", do_a); else passed++;
    checks++; if (cnt_a !== 3'd0) $display("FAIL reset_count: got %0d want 0", cnt_a); else passed++;
    checks++; if ({ri_b, vo_b, do_b, cnt_b} !== {1'b1, 1'b0, 8'h00, 2'd0})
      $display("FAIL reset_b_outputs: got ri=%b vo=%b do=%h cnt=%0d want 1 0 00 0", ri_b, vo_b, do_b, cnt_b);
    else passed++;
    step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({ri_a, cnt_a} !== {1'b1, 3'(i)})
        $display("FAIL fill_count: got ready_in=%b count=%0d want 1 %0d", ri_a, cnt_a, i);
      else passed++;
      step_a(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0);
    end
    checks++; if ({ri_a, cnt_a} !== {1'b0, 3'd4})
      $display("FAIL full_flags: got ready_in=%b count=%0d want 0 4", ri_a, cnt_a);
    else passed++;
    step_a(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    checks++; if ({ri_a, cnt_a} !== {1'b0, 3'd4})
      $display("FAIL overflow_rejected: got ready_in=%b count=%0d want 0 4", ri_a, cnt_a);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({vo_a, do_a} !== {1'b1, 8'(8'h11 * (i + 1))} || do_a !== sba[0])
        $display("FAIL drain_data: got vo=%b data=%h want 1 %h", vo_a, do_a, 8'(8'h11 * (i + 1)));
      else passed++;
      step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++; if ({vo_a, do_a, cnt_a} !== {1'b0, 8'h00, 3'd0})
      $display("FAIL drained_empty: got vo=%b data=%h count=%0d want 0 00 0", vo_a, do_a, cnt_a);
    else passed++;
  endtask

  task automatic test_push_pop();
    step_a(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 8'hF1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      checks++; if (cnt_a !== 3'd2 || vo_a !== 1'b1 || do_a !== sba[0])
        $display("FAIL push_pop_steady: got count=%0d data=%h want 2 %h", cnt_a, do_a, sba[0]);
      else passed++;
      step_a(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    end
    for (int i = 9; i <= 10; i++) begin
      checks++; if (do_a !== 8'(i))
        $display("FAIL push_pop_tail: got %h want %h", do_a, 8'(i));
      else passed++;
      step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (cnt_a !== 3'd0) $display("FAIL push_pop_empty: got %0d want 0", cnt_a); else passed++;
  endtask

  task automatic test_wrap();
    int sent = 0;
    int got  = 0;
    step_b(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      logic ro;
      logic acc;
      ro  = 1'($urandom_range(0, 1));
      acc = (sent < 20) && (sbb.size() != 3);
      checks++; if (cnt_b !== 2'(sbb.size()) || vo_b !== (sbb.size() != 0))
        $display("FAIL wrap_count: got count=%0d vo=%b want %0d", cnt_b, vo_b, sbb.size());
      else passed++;
      if (ro && sbb.size() != 0) begin
        checks++; if ({vo_b, do_b} !== {1'b1, 8'(got + 1)})
          $display("FAIL wrap_order: got vo=%b data=%h want 1 %h", vo_b, do_b, 8'(got + 1));
        else passed++;
        got++;
      end
      step_b(sent < 20, 8'(sent + 1), ro, 1'b0, 1'b0);
      if (acc) sent++;
    end
    checks++; if (got != 20) $display("FAIL wrap_timeout: got %0d outputs want 20", got); else passed++;
  endtask

  task automatic test_mispredict();
    for (int i = 0; i < 4; i++) step_a(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    checks++; if (cnt_a !== 3'd4) $display("FAIL mp_prefill: got %0d want 4", cnt_a); else passed++;
    step_a(1'b1, 8'hBB, 1'b1, 1'b1, 1'b0);
    checks++; if ({cnt_a, vo_a, do_a, ri_a} !== {3'd0, 1'b0, 8'h00, 1'b1})
      $display("FAIL mp_flush: got count=%0d vo=%b data=%h ri=%b want 0 0 00 1", cnt_a, vo_a, do_a, ri_a);
    else passed++;
    step_a(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
    checks++; if ({cnt_a, vo_a, do_a} !== {3'd1, 1'b1, 8'hCC})
      $display("FAIL mp_refill: got count=%0d vo=%b data=%h want 1 1 cc", cnt_a, vo_a, do_a);
    else passed++;
    step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if ({cnt_a, vo_a} !== {3'd0, 1'b0})
      $display("FAIL mp_drain: got count=%0d vo=%b want 0 0", cnt_a, vo_a);
    else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step_a(1'b1, 8'(8'h31 + i), 1'b0, 1'b0, 1'b0);
    checks++; if (cnt_a !== 3'd3) $display("FAIL rst_prefill: got %0d want 3", cnt_a); else passed++;
    for (int i = 0; i < 2; i++) begin
      step_a(1'b1, 8'h3F, 1'b1, 1'b0, 1'b1);
      checks++; if ({ri_a, vo_a, do_a, cnt_a} !== {1'b1, 1'b0, 8'h00, 3'd0})
        $display("FAIL rst_hold: got ri=%b vo=%b data=%h count=%0d want 1 0 00 0", ri_a, vo_a, do_a, cnt_a);
      else passed++;
    end
    step_a(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    checks++; if ({cnt_a, vo_a, do_a} !== {3'd1, 1'b1, 8'h77})
      $display("FAIL rst_first_push: got count=%0d vo=%b data=%h want 1 1 77", cnt_a, vo_a, do_a);
    else passed++;
    step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (cnt_a !== 3'd0) $display("FAIL rst_alone: got %0d want 0", cnt_a); else passed++;
  endtask

  task automatic test_empty_pop();
    for (int i = 0; i < 5; i++) begin
      step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++; if ({cnt_a, vo_a, ri_a} !== {3'd0, 1'b0, 1'b1})
        $display("FAIL empty_pop: got count=%0d vo=%b ri=%b want 0 0 1", cnt_a, vo_a, ri_a);
      else passed++;
    end
    step_a(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 8'h9A, 1'b0, 1'b0, 1'b0);
    checks++; if ({cnt_a, do_a} !== {3'd2, 8'h99} || do_a !== sba[0])
      $display("FAIL empty_pop_ptr: got count=%0d data=%h want 2 99", cnt_a, do_a);
    else passed++;
    step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (do_a !== 8'h9A) $display("FAIL empty_pop_next: got %h want 9a", do_a); else passed++;
    step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_a = 1'b1; mp_a = 1'b0; vi_a = 1'b0; ro_a = 1'b0; di_a = '0;
    rst_b = 1'b1; mp_b = 1'b0; vi_b = 1'b0; ro_b = 1'b0; di_b = '0;
    test_reset();
    test_fill_drain();
    test_push_pop();
    test_wrap();
    test_mispredict();
    test_reset_mid();
    test_empty_pop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
